// File: rtl/toeplitz_pkg.sv
// Shared definitions for the iterative Toeplitz hash.
//   state_t   : FSM encoding (IDLE / RUN / OUT)
//   key_w()   : key width for a given message/tag width
//   nchunk()  : fold cycles for a given message/chunk width
//   ref_hash(): direct GF(2) matrix-vector reference at the default widths
package toeplitz_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_OUT
  } state_t;

  localparam int DEF_DIN_W   = 192;
  localparam int DEF_DOUT_W  = 40;
  localparam int DEF_CHUNK_W = 32;

  function automatic int key_w(input int din_w, input int dout_w);
    return din_w + dout_w - 1;
  endfunction

  function automatic int nchunk(input int din_w, input int chunk_w);
    return din_w / chunk_w;
  endfunction

  localparam int DEF_KEY_W = key_w(DEF_DIN_W, DEF_DOUT_W);

  // tag[i] = XOR_j key[i-j+DIN_W-1] & din[j]
  function automatic logic [DEF_DOUT_W-1:0] ref_hash(
    input logic [DEF_DIN_W-1:0] din,
    input logic [DEF_KEY_W-1:0] key
  );
    logic [DEF_DOUT_W-1:0] h;
    h = '0;
    for (int unsigned i = 0; i < DEF_DOUT_W; i++) begin
      for (int unsigned j = 0; j < DEF_DIN_W; j++) begin
        h[i] = h[i] ^ (key[i + DEF_DIN_W - 1 - j] & din[j]);
      end
    end
    return h;
  endfunction

endpackage

// File: rtl/toeplitz_hash_iter_chunk_xor.sv
// toeplitz_chunk_xor: combinational CHUNK_W x DOUT_W partial product.
//   i_chunk  : CHUNK_W message bits of the current slice
//   i_kslice : CHUNK_W+DOUT_W-1 key bits matching that slice
//   o_part   : DOUT_W-bit partial tag, o_part[i] = XOR_k chunk[k] & kslice[i-k+CHUNK_W-1]
module toeplitz_chunk_xor #(
  parameter int CHUNK_W = 32,
  parameter int DOUT_W  = 40
) (
  input  logic [CHUNK_W-1:0]        i_chunk,
  input  logic [CHUNK_W+DOUT_W-2:0] i_kslice,
  output logic [DOUT_W-1:0]         o_part
);

  always_comb begin
    o_part = '0;
    for (int unsigned i = 0; i < DOUT_W; i++) begin
      for (int unsigned k = 0; k < CHUNK_W; k++) begin
        o_part[i] = o_part[i] ^ (i_chunk[k] & i_kslice[i + CHUNK_W - 1 - k]);
      end
    end
  end

endmodule

// File: rtl/toeplitz_hash_iter.sv
// toeplitz_hash_iter: iterative Toeplitz universal hash, one CHUNK_W slice per cycle.
// Optional feature macro: TOEPLITZ_OTP_EN (adds otp_key, tag = hash ^ otp).
// Ports:
//   clk, rst                  : clock, synchronous active-high reset
//   ss_tdata/tvalid/tready    : message input stream (DIN_W bits)
//   toeplitz_key              : KEY_W-bit key, sampled on input handshake
//   otp_key                   : DOUT_W-bit pad (TOEPLITZ_OTP_EN only)
//   sm_tdata/tvalid/tready    : tag output stream (DOUT_W bits)
//   busy                      : high while hashing or presenting a tag
module toeplitz_hash_iter
  import toeplitz_pkg::*;
#(
  parameter  int DIN_W   = 192,
  parameter  int DOUT_W  = 40,
  parameter  int CHUNK_W = 32,
  localparam int KEY_W   = key_w(DIN_W, DOUT_W),
  localparam int NCHUNK  = nchunk(DIN_W, CHUNK_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DIN_W-1:0]  ss_tdata,
  input  logic              ss_tvalid,
  output logic              ss_tready,
  input  logic [KEY_W-1:0]  toeplitz_key,
`ifdef TOEPLITZ_OTP_EN
  input  logic [DOUT_W-1:0] otp_key,
`endif
  output logic [DOUT_W-1:0] sm_tdata,
  output logic              sm_tvalid,
  input  logic              sm_tready,
  output logic              busy
);

  if (DIN_W % CHUNK_W != 0) begin : g_bad_chunk
    $error("toeplitz_hash_iter: CHUNK_W must divide DIN_W");
  end

  localparam int SLW   = CHUNK_W + DOUT_W - 1;
  localparam int SL_LO = DIN_W - CHUNK_W;
  localparam int CNT_W = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NCHUNK - 1);

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [DIN_W-1:0]   r_din;
  logic [KEY_W-1:0]   r_key;
  logic [DOUT_W-1:0]  r_acc;
  logic [DOUT_W-1:0]  r_tag;
  logic               r_valid;
  logic [DOUT_W-1:0]  w_mask;
  logic [DOUT_W-1:0]  w_part;
  logic               w_rdy;
  logic               w_take;

`ifdef TOEPLITZ_OTP_EN
  logic [DOUT_W-1:0]  r_otp;
  assign w_mask = r_otp;
`else
  assign w_mask = '0;
`endif

  assign w_rdy  = ~rst & ((r_state == S_IDLE) | ((r_state == S_OUT) & sm_tready));
  assign w_take = ss_tvalid & w_rdy;

  // Chunk c uses din[c*CHUNK_W +: CHUNK_W] and key[DIN_W-(c+1)*CHUNK_W +: SLW].
  // The latched copies are shifted each RUN cycle (din right, key left) so both
  // slices sit at fixed positions instead of needing wide variable muxes.
  toeplitz_chunk_xor #(
    .CHUNK_W(CHUNK_W),
    .DOUT_W (DOUT_W)
  ) u_chunk (
    .i_chunk (r_din[CHUNK_W-1:0]),
    .i_kslice(r_key[SL_LO +: SLW]),
    .o_part  (w_part)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_din   <= '0;
      r_key   <= '0;
      r_acc   <= '0;
      r_tag   <= '0;
      r_valid <= 1'b0;
`ifdef TOEPLITZ_OTP_EN
      r_otp   <= '0;
`endif
    end else begin
      case (r_state)
        S_RUN: begin
          r_acc <= r_acc ^ w_part;
          r_din <= r_din >> CHUNK_W;
          r_key <= r_key << CHUNK_W;
          if (r_cnt == LAST) begin
            r_tag   <= r_acc ^ w_part ^ w_mask;
            r_valid <= 1'b1;
            r_state <= S_OUT;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_OUT: begin
          if (sm_tready) begin
            r_valid <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
      // Acceptance overrides the IDLE/OUT transitions above (zero-bubble restart).
      if (w_take) begin
        r_din   <= ss_tdata;
        r_key   <= toeplitz_key;
`ifdef TOEPLITZ_OTP_EN
        r_otp   <= otp_key;
`endif
        r_acc   <= '0;
        r_cnt   <= '0;
        r_state <= S_RUN;
      end
    end
  end

  assign ss_tready = w_rdy;
  assign sm_tdata  = r_tag;
  assign sm_tvalid = r_valid;
  assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_toeplitz_hash_iter.sv
module tb_toeplitz_hash_iter;
  import toeplitz_pkg::*;

  localparam int DW = DEF_DIN_W;
  localparam int OW = DEF_DOUT_W;
  localparam int KW = DEF_KEY_W;

  logic          clk;
  logic          rst;
  logic [DW-1:0] ss_tdata;
  logic          ss_tvalid;
  logic          ss_tready;
  logic [KW-1:0] toeplitz_key;
  logic [OW-1:0] otp_key;
  logic [OW-1:0] sm_tdata;
  logic          sm_tvalid;
  logic          sm_tready;
  logic          busy;

  int checks   = 0;
  int failures = 0;
  logic [OW-1:0] q[$];

  toeplitz_hash_iter #(
    .DIN_W  (DW),
    .DOUT_W (OW),
    .CHUNK_W(DEF_CHUNK_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ss_tdata    (ss_tdata),
    .ss_tvalid   (ss_tvalid),
    .ss_tready   (ss_tready),
    .toeplitz_key(toeplitz_key),
`ifdef TOEPLITZ_OTP_EN
    .otp_key     (otp_key),
`endif
    .sm_tdata    (sm_tdata),
    .sm_tvalid   (sm_tvalid),
    .sm_tready   (sm_tready),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Tag monitor: pops the scoreboard on each output handshake.
  always @(negedge clk) begin
    if (!rst && sm_tvalid && sm_tready) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_tag: got %h expected none", sm_tdata);
      end else begin
        check("tag", 64'(sm_tdata), 64'(q.pop_front()));
      end
    end
  end

  function automatic logic [OW-1:0] with_otp(input logic [OW-1:0] h, input logic [OW-1:0] otp);
`ifdef TOEPLITZ_OTP_EN
    return h ^ otp;
`else
    return h;
`endif
  endfunction

  // Present a message; returns one time unit after the accepting clock edge.
  task automatic send(input logic [DW-1:0] din, input logic [KW-1:0] key,
                      input logic [OW-1:0] otp, input logic [OW-1:0] exp);
    int n;
    ss_tdata     = din;
    toeplitz_key = key;
    otp_key      = otp;
    ss_tvalid    = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (ss_tready) break;
      n++;
      if (n > 100) begin
        check("accept_timeout", 64'(n), 64'(0));
        break;
      end
    end
    q.push_back(exp);
    @(posedge clk);
    #1;
    ss_tvalid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    check("drain", 64'(q.size()), 64'(0));
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [DW-1:0] din;
    logic [KW-1:0] key;
    logic [OW-1:0] otp;
    logic [OW-1:0] exp;
  } vec_t;

  vec_t vecs[6];

  function automatic logic [KW-1:0] rand_key();
    logic [255:0] t;
    for (int i = 0; i < 8; i++) t[i*32 +: 32] = $urandom();
    return t[KW-1:0];
  endfunction

  function automatic logic [DW-1:0] rand_din();
    logic [DW-1:0] t;
    for (int i = 0; i < 6; i++) t[i*32 +: 32] = $urandom();
    return t;
  endfunction

  initial begin
    logic [KW-1:0] k1, k2, kstd;
    logic [DW-1:0] dstd, one_hi;
    logic [OW-1:0] o1, expa, expb;
    int n;

    k1     = rand_key();
    k2     = rand_key();
    kstd   = {7'h5A, {7{32'hDEADBEEF}}};
    dstd   = 192'h0123456789ABCDEF_FEDCBA9876543210_0F1E2D3C4B5A6978;
    one_hi = '0;
    one_hi[DW-1] = 1'b1;
    o1     = 40'h12_3456_789A;

    vecs[0] = '{din: '0,          key: k1,   otp: o1,  exp: with_otp('0, o1)};
    vecs[1] = '{din: DW'(1),      key: k1,   otp: '0,  exp: k1[230:191]};
    vecs[2] = '{din: one_hi,      key: k2,   otp: '0,  exp: k2[39:0]};
    vecs[3] = '{din: dstd,        key: kstd, otp: o1,  exp: with_otp(ref_hash(dstd, kstd), o1)};
    vecs[4] = '{din: '1,          key: k2,   otp: '0,  exp: ref_hash('1, k2)};
    vecs[5].din = rand_din();
    vecs[5].key = rand_key();
    vecs[5].otp = 40'hA5_5A5A_A5A5;
    vecs[5].exp = with_otp(ref_hash(vecs[5].din, vecs[5].key), vecs[5].otp);

    rst = 1'b1; ss_tvalid = 1'b0; ss_tdata = '0; toeplitz_key = '0; otp_key = '0;
    sm_tready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ss_tready", 64'(ss_tready), 64'(0));
    check("rst_sm_tvalid", 64'(sm_tvalid), 64'(0));
    check("rst_sm_tdata",  64'(sm_tdata),  64'(0));
    check("rst_busy",      64'(busy),      64'(0));
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_ss_tready", 64'(ss_tready), 64'(1));

    // Table-driven vectors.
    for (int i = 0; i < 6; i++) begin
      send(vecs[i].din, vecs[i].key, vecs[i].otp, vecs[i].exp);
      drain();
    end

    // Latency: din=0 gives tag valid exactly 6 cycles after the handshake edge.
    send('0, k2, '0, with_otp('0, '0));
    n = 0;
    while (!sm_tvalid && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("latency", 64'(n), 64'(6));
    drain();

    // Inputs changed after the handshake must not affect the hash in flight.
    send(dstd, k1, o1, with_otp(ref_hash(dstd, k1), o1));
    ss_tdata = ~dstd; toeplitz_key = ~k1; otp_key = ~o1;
    drain();

`ifdef TOEPLITZ_OTP_EN
    send('0, k1, 40'hFF_FFFF_FFFF, 40'hFF_FFFF_FFFF);
    toeplitz_key = ~k1; otp_key = '0;
    drain();
`endif

    // Backpressure: tag held 10 cycles, then zero-bubble second message.
    sm_tready = 1'b0;
    expa = with_otp(ref_hash(dstd, k2), o1);
    send(dstd, k2, o1, expa);
    n = 0;
    while (!sm_tvalid && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    for (int c = 0; c < 10; c++) begin
      check("hold_tvalid", 64'(sm_tvalid), 64'(1));
      check("hold_tdata",  64'(sm_tdata),  64'(expa));
      check("hold_ss_tready", 64'(ss_tready), 64'(0));
      @(posedge clk);
      #1;
    end
    expb = with_otp(ref_hash(vecs[5].din, k1), '0);
    ss_tdata = vecs[5].din; toeplitz_key = k1; otp_key = '0;
    ss_tvalid = 1'b1;
    sm_tready = 1'b1;
    @(negedge clk);
    check("b2b_ss_tready", 64'(ss_tready), 64'(1));
    q.push_back(expb);
    @(posedge clk);
    #1;
    ss_tvalid = 1'b0;
    check("b2b_busy", 64'(busy), 64'(1));
    check("b2b_tvalid_drop", 64'(sm_tvalid), 64'(0));
    drain();

    // Reset during chunk 3 aborts the hash with no tag.
    send(dstd, kstd, '0, '0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    q.delete();
    check("abort_busy", 64'(busy), 64'(0));
    check("abort_tvalid", 64'(sm_tvalid), 64'(0));
    repeat (10) @(posedge clk);
    #1;
    check("abort_no_tag", 64'(sm_tvalid), 64'(0));
    send(vecs[4].din, kstd, o1, with_otp(ref_hash(vecs[4].din, kstd), o1));
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
